// File: rtl/sha1_block_ctrl_pkg.sv
// sha1_block_ctrl_pkg: shared state encoding, SHA-1 constants and round/word boundaries.
package sha1_block_ctrl_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_STORE, S_DONE} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } abcde_t;

    localparam logic [31:0] H0_IV = 32'h67452301;
    localparam logic [31:0] H1_IV = 32'hEFCDAB89;
    localparam logic [31:0] H2_IV = 32'h98BADCFE;
    localparam logic [31:0] H3_IV = 32'h10325476;
    localparam logic [31:0] H4_IV = 32'hC3D2E1F0;
    localparam abcde_t IV = '{a: H0_IV, b: H1_IV, c: H2_IV, d: H3_IV, e: H4_IV};

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    localparam logic [6:0] T_20    = 7'd20;
    localparam logic [6:0] T_40    = 7'd40;
    localparam logic [6:0] T_60    = 7'd60;
    localparam logic [6:0] T_80    = 7'd80;
    localparam logic [6:0] N_WORDS = 7'd16;
    localparam logic [6:0] N_DIG   = 7'd5;

    // Word i of a chaining value, H0 first.
    function automatic logic [31:0] word_sel(abcde_t x, logic [2:0] i);
        return i == 3'd0 ? x.a : i == 3'd1 ? x.b : i == 3'd2 ? x.c : i == 3'd3 ? x.d : x.e;
    endfunction

endpackage

// File: rtl/sha1_round.sv
// sha1_round: one combinational SHA-1 round (f/K select, temp adder, register rotation).
module sha1_round
    import sha1_block_ctrl_pkg::*;
(
    input  logic [6:0]  t,
    input  abcde_t      s,
    input  logic [31:0] w,
    output abcde_t      s_n
);

    logic [31:0] f, k, temp;

    always_comb begin
        f = t < T_20 ? (s.b & s.c) | (~s.b & s.d) :
            (t < T_40 || t >= T_60) ? s.b ^ s.c ^ s.d :
            (s.b & s.c) | (s.b & s.d) | (s.c & s.d);
        k = t < T_20 ? K0 : t < T_40 ? K1 : t < T_60 ? K2 : K3;
        temp = {s.a[26:0], s.a[31:27]} + f + s.e + k + w;
        s_n = '{a: temp, b: s.a, c: {s.b[1:0], s.b[31:2]}, d: s.c, e: s.d};
    end

endmodule

// File: rtl/sha1_block_ctrl.sv
// sha1_block_ctrl: fetches a 16-word block, runs 80 SHA-1 rounds, folds into H and writes the digest back.
// Optional SHA1_BLOCK_CTRL_PERF_EN adds perf_cycles_o, a saturating count of busy cycles.
module sha1_block_ctrl
    import sha1_block_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              init_i,
    input  logic [ADDR_W-1:0] blk_addr_i,
    input  logic [ADDR_W-1:0] dig_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
`ifdef SHA1_BLOCK_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles_o
`endif
);

    state_t            state, state_n;
    logic [6:0]        cnt;
    logic [ADDR_W-1:0] blk_q, dig_q, off;
    abcde_t            h, v, v_n;
    logic [31:0]       w_buf [16];
    logic [31:0]       wt, mix;
    logic [3:0]        j;

    assign j = cnt[3:0];
    assign off = ADDR_W'({cnt, 2'b00});

    // Circular 16-word schedule: slot j still holds W[t-16] when round t reads it.
    always_comb begin
        mix = w_buf[j + 4'd13] ^ w_buf[j + 4'd8] ^ w_buf[j + 4'd2] ^ w_buf[j];
        wt = cnt < N_WORDS ? w_buf[j] : {mix[30:0], mix[31]};
    end

    sha1_round u_round (.t(cnt), .s(v), .w(wt), .s_n(v_n));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = start_i ? S_LOAD : S_IDLE;
            S_LOAD:  state_n = (mem_ack_i && cnt == N_WORDS - 7'd1) ? S_ROUND : S_LOAD;
            S_ROUND: state_n = cnt == T_80 - 7'd1 ? S_FINAL : S_ROUND;
            S_FINAL: state_n = S_STORE;
            S_STORE: state_n = (mem_ack_i && cnt == N_DIG - 7'd1) ? S_DONE : S_STORE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = state != S_IDLE;
        done_o = state == S_DONE;
        mem_req_o = state == S_LOAD || state == S_STORE;
        mem_we_o = state == S_STORE;
        mem_addr_o = state == S_LOAD ? blk_q + off : state == S_STORE ? dig_q + off : '0;
        mem_wdata_o = state == S_STORE ? DATA_W'(word_sel(h, cnt[2:0])) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            h <= IV;
            v <= '0;
            blk_q <= '0;
            dig_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    blk_q <= blk_addr_i & ~ADDR_W'(3);
                    dig_q <= dig_addr_i & ~ADDR_W'(3);
                    cnt <= '0;
                    if (init_i) h <= IV;
                end
                S_LOAD: if (mem_ack_i) begin
                    w_buf[j] <= mem_rdata_i[31:0];
                    cnt <= cnt == N_WORDS - 7'd1 ? '0 : cnt + 7'd1;
                    if (cnt == N_WORDS - 7'd1) v <= h;
                end
                S_ROUND: begin
                    w_buf[j] <= wt;
                    v <= v_n;
                    cnt <= cnt == T_80 - 7'd1 ? '0 : cnt + 7'd1;
                end
                S_FINAL: h <= '{a: h.a + v.a, b: h.b + v.b, c: h.c + v.c, d: h.d + v.d, e: h.e + v.e};
                S_STORE: if (mem_ack_i) cnt <= cnt == N_DIG - 7'd1 ? '0 : cnt + 7'd1;
                default: ;
            endcase
        end
    end

`ifdef SHA1_BLOCK_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) perf_cycles_o <= '0;
        else if (state == S_IDLE && start_i) perf_cycles_o <= '0;
        else if (busy_o && perf_cycles_o != '1) perf_cycles_o <= perf_cycles_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_sha1_block_ctrl.sv
// tb_sha1_block_ctrl: table-driven digest vectors plus reset, rogue-start and wait-state sequences.
module tb_sha1_block_ctrl;

    typedef struct packed {
        logic [15:0][31:0] w;
        logic [31:0]       blk;
        logic [31:0]       dig;
        logic              init;
        logic              rnd;
        logic              cd;
        logic [7:0]        rogue;
        logic [7:0]        lat;
        logic [4:0][31:0]  exp;
    } vec_t;

    localparam logic [4:0][31:0] ABC = {32'h9CD0D89D, 32'h7850C26C, 32'hBA3E2571, 32'h4706816A, 32'hA9993E36};
    localparam logic [4:0][31:0] TWO = {32'hE54670F1, 32'hF95129E5, 32'hBAAE4AA1, 32'h1C3BD26E, 32'h84983E44};

    logic        clk = 0, rst = 1, start_i = 0, init_i = 0;
    logic [31:0] blk_addr_i = 0, dig_addr_i = 0;
    logic        busy_o, done_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
`ifdef SHA1_BLOCK_CTRL_PERF_EN
    logic [31:0] perf_cycles_o;
`endif

    sha1_block_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .init_i(init_i),
        .blk_addr_i(blk_addr_i), .dig_addr_i(dig_addr_i),
        .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i)
`ifdef SHA1_BLOCK_CTRL_PERF_EN
        , .perf_cycles_o(perf_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] m1 [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                             32'h66676869, 32'h6768696A, 32'h68696A6B, 32'h696A6B6C, 32'h6A6B6C6D,
                             32'h6B6C6D6E, 32'h6C6D6E6F, 32'h6D6E6F70, 32'h6E6F7071};
    logic [31:0] mem [256];
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int checks = 0, failures = 0;
    int wmode = 0, fixed_wait = 0, wait_cnt = 0, wait_tgt = 0;
    int n_rd = 0, n_wr = 0, stab_bad = 0;
    bit spur = 0, pend = 0, p_we = 0;
    logic [31:0] p_addr = 0, p_wdata = 0;

    // Memory slave: ack after wait_tgt cycles of an outstanding request.
    always_comb mem_ack_i = spur || (mem_req_o && wait_cnt >= wait_tgt);
    always_comb mem_rdata_i = mem[mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (rst || !mem_req_o || mem_ack_i) begin
            wait_cnt <= 0;
            wait_tgt <= wmode != 0 ? int'($urandom_range(0, 5)) : fixed_wait;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Transfer log and request-stability monitor.
    always @(negedge clk) begin
        if (pend && (!mem_req_o || mem_we_o !== p_we || mem_addr_o !== p_addr || mem_wdata_o !== p_wdata))
            stab_bad++;
        if (mem_req_o && mem_ack_i && !rst) begin
            if (mem_we_o) begin
                wr_addr[n_wr % 64] = mem_addr_o;
                wr_data[n_wr % 64] = mem_wdata_o;
                n_wr++;
            end else begin
                n_rd++;
            end
        end
        pend = mem_req_o && !mem_ack_i && !rst;
        p_we = mem_we_o;
        p_addr = mem_addr_o;
        p_wdata = mem_wdata_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_run(input logic [31:0] blk, input logic [31:0] dig, input bit init,
                          input int rogue, output int n);
        @(negedge clk);
        start_i = 1;
        init_i = init;
        blk_addr_i = blk;
        dig_addr_i = dig;
        @(negedge clk);
        start_i = 0;
        init_i = 0;
        n = 1;
        chk("busy_after_start", {31'd0, busy_o}, 1);
        while (!done_o && n < 2000) begin
            start_i = n == rogue;
            init_i = start_i;
            blk_addr_i = 32'h0;
            @(negedge clk);
            n++;
        end
        start_i = 0;
        init_i = 0;
        chk("done_seen", {31'd0, done_o}, 1);
    endtask

    task automatic chk_result(input int rd0, input int wr0, input int st0, input logic [31:0] dig,
                              input bit cd, input logic [4:0][31:0] exp);
        chk("read_count", n_rd - rd0, 16);
        chk("write_count", n_wr - wr0, 5);
        chk("req_stable", stab_bad - st0, 0);
        if (cd) begin
            for (int k = 0; k < 5; k++) begin
                chk("dig_addr", wr_addr[(wr0 + k) % 64], {dig[31:2], 2'b00} + 32'(4 * k));
                chk("dig_word", wr_data[(wr0 + k) % 64], exp[k]);
            end
        end
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done_o}, 0);
        @(negedge clk);
        chk("idle_after_done", {31'd0, busy_o}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv [4];
        int n, rd0, wr0, st0;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        tv[0] = '0;
        tv[0].w[0] = 32'h61626380;
        tv[0].w[15] = 32'h00000018;
        tv[0].blk = 32'h000; tv[0].dig = 32'h200; tv[0].init = 1; tv[0].cd = 1;
        tv[0].lat = 8'd103; tv[0].exp = ABC;
        tv[1] = '0;
        for (int k = 0; k < 14; k++) tv[1].w[k] = m1[k];
        tv[1].w[14] = 32'h80000000;
        tv[1].blk = 32'h042; tv[1].dig = 32'h220; tv[1].init = 1; tv[1].lat = 8'd103;
        tv[2] = '0;
        tv[2].w[15] = 32'h000001C0;
        tv[2].blk = 32'h080; tv[2].dig = 32'h241; tv[2].cd = 1; tv[2].rogue = 8'd40;
        tv[2].lat = 8'd103; tv[2].exp = TWO;
        tv[3] = tv[0];
        tv[3].blk = 32'h0C0; tv[3].dig = 32'h260; tv[3].rnd = 1; tv[3].lat = 8'd0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 16; k++) mem[tv[i].blk[9:2] + k] = tv[i].w[k];

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_done", {31'd0, done_o}, 0);
        chk("rst_req", {31'd0, mem_req_o}, 0);
        chk("rst_we", {31'd0, mem_we_o}, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
`ifdef SHA1_BLOCK_CTRL_PERF_EN
        chk("rst_perf", perf_cycles_o, 0);
`endif
        rst = 0;

        for (int i = 0; i < 4; i++) begin
            wmode = int'(tv[i].rnd);
            fixed_wait = 0;
            rd0 = n_rd; wr0 = n_wr; st0 = stab_bad;
            do_run(tv[i].blk, tv[i].dig, tv[i].init, int'(tv[i].rogue), n);
            if (tv[i].lat != 0) chk("latency", n, {24'd0, tv[i].lat});
            chk_result(rd0, wr0, st0, tv[i].dig, tv[i].cd, tv[i].exp);
        end

        // Reset while word 7 of the block is on the bus, H must return to the IV.
        wmode = 0;
        fixed_wait = 0;
        @(negedge clk);
        start_i = 1; init_i = 0; blk_addr_i = tv[0].blk; dig_addr_i = 32'h280;
        @(negedge clk);
        start_i = 0;
        repeat (7) @(negedge clk);
        chk("load_word7_addr", mem_addr_o, 32'h1C);
        chk("load_word7_req", {31'd0, mem_req_o}, 1);
        rst = 1;
        @(negedge clk);
        chk("req_after_rst", {31'd0, mem_req_o}, 0);
        chk("busy_after_rst", {31'd0, busy_o}, 0);
        rst = 0;
        spur = 1;
        repeat (3) @(negedge clk);
        chk("spurious_ack_busy", {31'd0, busy_o}, 0);
        chk("spurious_ack_req", {31'd0, mem_req_o}, 0);
        spur = 0;
        rd0 = n_rd; wr0 = n_wr; st0 = stab_bad;
        do_run(tv[0].blk, 32'h2A0, 0, 0, n);
        chk("latency_after_rst", n, 103);
        chk_result(rd0, wr0, st0, 32'h2A0, 1, ABC);

`ifdef SHA1_BLOCK_CTRL_PERF_EN
        fixed_wait = 2;
        rd0 = n_rd; wr0 = n_wr; st0 = stab_bad;
        do_run(tv[0].blk, 32'h2C0, 1, 0, n);
        chk("latency_2wait", n, 145);
        chk_result(rd0, wr0, st0, 32'h2C0, 1, ABC);
        chk("perf_cycles", perf_cycles_o, 145);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha1_block_ctrl.md
Name: sha1_block_ctrl

Overview:
Sequencer for the SHA-1 assist path. On a start command it fetches one 512-bit message block (16 words) over a simple memory handshake and runs the 80 SHA-1 rounds, one per cycle, using an on-the-fly message schedule. It then folds the result into the chaining state H0..H4 and writes the 5-word digest back to memory. It sits between the core's SHA-1 custom-instruction decode, which issues start and addresses, and the data-memory arbiter.

Parameters:
ADDR_W, 32, width of memory byte addresses
DATA_W, 32, word width; fixed by SHA-1, must be 32

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_i  in  1  one-cycle command strobe
init_i  in  1  sampled with start_i; 1 = load standard IV into H before the block
blk_addr_i  in  ADDR_W  byte address of word 0 of the message block
dig_addr_i  in  ADDR_W  byte address where H0..H4 are written
busy_o  out  1  high from the cycle after start is accepted until DONE exits
done_o  out  1  one-cycle pulse when the digest write-back completes
mem_req_o  out  1  bus request
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  ADDR_W  word-aligned byte address
mem_wdata_o  out  DATA_W  write data
mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i
mem_ack_i  in  1  transfer complete this cycle

Behaviour:
- Reset values:
  - state=IDLE; busy_o, done_o, mem_req_o, mem_we_o = 0.
  - mem_addr_o and mem_wdata_o = 0.
  - H0..H4 = 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0.
  - Round counter = 0.
- States: IDLE -> LOAD -> ROUND -> FINAL -> STORE -> DONE -> IDLE.
- IDLE:
  - start_i=1 latches blk_addr_i, dig_addr_i and init_i.
  - If init_i=1, H is set to the IV on the same edge.
  - Next state is LOAD.
- LOAD:
  - Issues 16 reads at blk_addr+4*k, k=0..15.
  - Each word is stored as-is into schedule buffer W[k]; the memory word is already big-endian-ordered.
  - After word 15 is acked, load a..e from H0..H4 and go to ROUND.
- Handshake (all memory states):
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable until mem_ack_i.
  - Ack may arrive in the same cycle req rises (zero-wait).
  - The next request is driven the following cycle, so back-to-back transfers are allowed.
  - mem_ack_i while mem_req_o=0 is ignored.
- ROUND, t=0..79, one round per cycle:
  - Schedule word: Wt = W[t] for t<16. Otherwise Wt = rotl1(W[(t-3)%16]^W[(t-8)%16]^W[(t-14)%16]^W[t%16]), written back to W[t%16].
  - f and K by t:
    - t<20: Ch, 5A827999.
    - t<40: Parity, 6ED9EBA1.
    - t<60: Maj, 8F1BBCDC.
    - else: Parity, CA62C1D6.
  - temp = rotl5(a)+f+e+K+Wt, mod 2^32.
  - Update: e=d, d=c, c=rotl30(b), b=a, a=temp.
  - At t=79, go to FINAL.
- FINAL (1 cycle): Hi = Hi + {a,b,c,d,e}i, mod 2^32. Then go to STORE.
- STORE: 5 writes of H0..H4 to dig_addr+0,4,8,12,16. After the 5th ack, go to DONE.
- DONE (1 cycle): done_o=1, busy_o=1. Then go to IDLE.
- Latency: with zero-wait ack, done_o is high exactly 103 cycles after the start edge (16+80+1+5+1).
- start_i while not IDLE is ignored; no queuing.
- H persists across blocks when init_i=0, so multi-block messages chain.
- rst mid-operation:
  - Next edge returns to IDLE and mem_req_o drops immediately.
  - H is reset to the IV.
  - Any in-flight transfer is abandoned; the arbiter must tolerate this.
- Low address bits [1:0] of blk_addr_i and dig_addr_i are forced to 0.

Optional Feature:
SHA1_BLOCK_CTRL_PERF_EN
- Defined: adds output perf_cycles_o [31:0].
  - Counts cycles with busy_o=1, including wait states.
  - Cleared on the accepted start, held after DONE, reset to 0.
  - Saturates at FFFFFFFF.
- Undefined: port and counter absent.

Decomposition:
- Shared package/defines:
  - State encodings.
  - IV constants H0..H4 and the four K constants.
  - Round boundaries 20/40/60/80, word count 16, digest word count 5.
- One natural sub-module, sha1_round: combinational f/K select, temp adder and rotations, taking t, a..e, Wt and returning next a..e.
- Schedule buffer and FSM stay in sha1_block_ctrl.

Test Plan:
- "abc" padded block (W0=61626380, W15=00000018, others 0), init_i=1, zero-wait ack -> digest A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D written at dig_addr; done_o 103 cycles after start.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with init_i=1, block 2 with init_i=0 -> final digest 84983E44 1C3BD26E BAAE4AA1 F95129E5 E54670F1.
- Random 0-5 cycle ack delays on the "abc" block -> same digest; req/addr/wdata stable while waiting; no duplicate or missing transfers.
- start_i pulsed during ROUND -> ignored; only one done_o; H unaffected by the second start.
- rst asserted during LOAD word 7, then a fresh "abc" run with init_i=0 -> mem_req_o low the cycle after reset; digest still A9993E36..., proving H was reset to the IV.
- PERF_EN defined, 2 wait cycles per transfer -> perf_cycles_o = 103+42 = 145 after done.
